// File: rtl/spi_adc_responder.sv
// SPI responder emulating a dual-channel serial ADC on a 2-bit MISO bus, oversampled on clk.
// Define ADC_RESP_RAMP_EN to serve an internal ramp (ch0) and its inverse (ch1) instead of ports.
module spi_adc_responder #(
    parameter int unsigned LEAD_ZEROS  = 4,
    parameter int unsigned DATA_W      = 12,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic [DATA_W-1:0] sample0_i,
    input  logic [DATA_W-1:0] sample1_i,
    input  logic              spi_cs_ni,
    input  logic              spi_sck_i,
    output logic [1:0]        spi_miso_o,
    output logic              busy_o,
    output logic              frame_done_o,
    output logic              frame_abort_o
);

    localparam int unsigned FrameLen = LEAD_ZEROS + DATA_W;
    localparam int unsigned CntW     = $clog2(FrameLen + 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    logic [SYNC_STAGES-1:0] cs_sync_q, sck_sync_q;
    logic                   cs_prev_q, sck_prev_q;
    logic [SYNC_STAGES:0]   sync_vld_q;
    logic                   cs_s, sck_s, edge_ok;
    logic                   cs_fall, cs_rise, sck_fall;

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [FrameLen-1:0]   sh0_q, sh0_d, sh1_q, sh1_d;
    logic                  done_q, done_d, abort_q, abort_d;
    logic [DATA_W-1:0]     ld0, ld1;

    always_ff @(posedge clk) begin
        if (rst) begin
            cs_sync_q  <= '1;
            sck_sync_q <= '1;
            cs_prev_q  <= 1'b1;
            sck_prev_q <= 1'b1;
            sync_vld_q <= '0;
        end else begin
            cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_ni};
            sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck_i};
            cs_prev_q  <= cs_s;
            sck_prev_q <= sck_s;
            sync_vld_q <= {sync_vld_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign cs_s  = cs_sync_q[SYNC_STAGES-1];
    assign sck_s = sck_sync_q[SYNC_STAGES-1];
    // Edges count only once the whole chain holds post-reset pin samples, so a CS
    // that stays low across reset is not mistaken for a new falling edge.
    assign edge_ok  = sync_vld_q[SYNC_STAGES];
    assign cs_fall  = edge_ok & cs_prev_q & ~cs_s;
    assign cs_rise  = edge_ok & ~cs_prev_q & cs_s;
    assign sck_fall = edge_ok & sck_prev_q & ~sck_s & ~cs_s;

`ifdef ADC_RESP_RAMP_EN
    logic [DATA_W-1:0] ramp_q;
    logic              unused_samples;

    always_ff @(posedge clk) begin
        if (rst) begin
            ramp_q <= '0;
        end else if (done_d) begin
            ramp_q <= ramp_q + DATA_W'(1);
        end
    end

    assign ld0            = ramp_q;
    assign ld1            = ~ramp_q;
    assign unused_samples = ^{sample0_i, sample1_i};
`else
    assign ld0 = sample0_i;
    assign ld1 = sample1_i;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh0_d   = sh0_q;
        sh1_d   = sh1_q;
        done_d  = 1'b0;
        abort_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cs_fall && en_i) begin
                    sh0_d   = FrameLen'(ld0);
                    sh1_d   = FrameLen'(ld1);
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                // CS rising wins over a coincident SCK falling edge.
                if (cs_rise) begin
                    state_d = StIdle;
                    abort_d = 1'b1;
                end else if (sck_fall) begin
                    if (cnt_q == CntW'(FrameLen - 1)) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        sh0_d = {sh0_q[FrameLen-2:0], 1'b0};
                        sh1_d = {sh1_q[FrameLen-2:0], 1'b0};
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StDone: begin
                if (cs_rise) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            sh0_q   <= '0;
            sh1_q   <= '0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh0_q   <= sh0_d;
            sh1_q   <= sh1_d;
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end

    assign spi_miso_o    = (state_q == StShift) ? {sh1_q[FrameLen-1], sh0_q[FrameLen-1]} : 2'b00;
    assign busy_o        = (state_q != StIdle);
    assign frame_done_o  = done_q;
    assign frame_abort_o = abort_q;

endmodule

// File: tb/tb_spi_adc_responder.sv
// Self-checking bench for spi_adc_responder: SPI master driver, frame-level reference model,
// and a scoreboard monitor that compares captured MISO words and pulse counts per frame.
module tb_spi_adc_responder;

    localparam int LZ = 4;
    localparam int DW = 12;
    localparam int SS = 2;
    localparam int N  = LZ + DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en_i = 1'b1;
    logic [DW-1:0] s0 = '0;
    logic [DW-1:0] s1 = '0;
    logic          spi_cs_ni = 1'b1;
    logic          spi_sck_i = 1'b1;
    logic [1:0]    spi_miso_o;
    logic          busy_o, frame_done_o, frame_abort_o;

    spi_adc_responder #(
        .LEAD_ZEROS (LZ),
        .DATA_W     (DW),
        .SYNC_STAGES(SS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en_i         (en_i),
        .sample0_i    (s0),
        .sample1_i    (s1),
        .spi_cs_ni    (spi_cs_ni),
        .spi_sck_i    (spi_sck_i),
        .spi_miso_o   (spi_miso_o),
        .busy_o       (busy_o),
        .frame_done_o (frame_done_o),
        .frame_abort_o(frame_abort_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int w0;
        int w1;
        int done;
        int abort;
        int busy;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   req_chk = 0;
    int   ack_chk = 0;
    bit   end_req = 1'b0;
    bit   end_done = 1'b0;
    int   exp_tot_done = 0;
    int   exp_tot_abort = 0;
    int   m_ramp = 0;

    // Monitor-owned state
    int   tot_done = 0;
    int   tot_abort = 0;
    int   d0 = 0;
    int   a0 = 0;
    int   cap0 = 0;
    int   cap1 = 0;
    int   busy_seen = 0;
    int   close_cnt = 0;
    bit   cs_prev = 1'b1;
    bit   sck_prev = 1'b1;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (frame_done_o) tot_done++;
        if (frame_abort_o) tot_abort++;
        if (cs_prev && !spi_cs_ni) begin
            cap0 = 0;
            cap1 = 0;
            busy_seen = 0;
            d0 = tot_done;
            a0 = tot_abort;
        end
        if (!spi_cs_ni && busy_o) busy_seen = 1;
        // MISO still holds the bit presented before this SCK fall.
        if (!spi_cs_ni && sck_prev && !spi_sck_i) begin
            cap0 = (cap0 << 1) | int'(spi_miso_o[0]);
            cap1 = (cap1 << 1) | int'(spi_miso_o[1]);
        end
        if (!cs_prev && spi_cs_ni) begin
            close_cnt = 10;
        end else if (close_cnt > 0) begin
            close_cnt--;
            if (close_cnt == 0) begin
                if (exp_q.size() == 0) begin
                    chk("frame_unexpected", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("ch0_word", cap0, e.w0);
                    chk("ch1_word", cap1, e.w1);
                    chk("done_pulses", tot_done - d0, e.done);
                    chk("abort_pulses", tot_abort - a0, e.abort);
                    chk("busy_in_frame", busy_seen, e.busy);
                    chk("busy_after_cs_high", int'(busy_o), 0);
                end
            end
        end
        if (req_chk != ack_chk) begin
            ack_chk++;
            chk("idle_busy", int'(busy_o), 0);
            chk("idle_miso", int'(spi_miso_o), 0);
            chk("idle_done", int'(frame_done_o), 0);
            chk("idle_abort", int'(frame_abort_o), 0);
        end
        if (end_req && !end_done) begin
            end_done = 1'b1;
            chk("frames_left", exp_q.size(), 0);
            chk("total_done", tot_done, exp_tot_done);
            chk("total_abort", tot_abort, exp_tot_abort);
            $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
            $finish;
        end
        cs_prev = spi_cs_ni;
        sck_prev = spi_sck_i;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // nb SCK falls in one CS-low window; rst pulsed after fall rst_at (0 = never).
    task automatic run_frame(input int nb, input bit en_start, input int rst_at, input int hlf);
        exp_t e;
        int   v0, v1;
`ifdef ADC_RESP_RAMP_EN
        v0 = m_ramp;
        v1 = (~m_ramp) & 'hFFF;
`else
        v0 = int'(s0);
        v1 = int'(s1);
`endif
        if (!en_start) begin
            e.w0 = 0;
            e.w1 = 0;
        end else if (rst_at > 0) begin
            e.w0 = (v0 >> (N - rst_at)) << (nb - rst_at);
            e.w1 = (v1 >> (N - rst_at)) << (nb - rst_at);
        end else if (nb <= N) begin
            e.w0 = v0 >> (N - nb);
            e.w1 = v1 >> (N - nb);
        end else begin
            e.w0 = v0 << (nb - N);
            e.w1 = v1 << (nb - N);
        end
        e.done  = (en_start && rst_at == 0 && nb >= N) ? 1 : 0;
        e.abort = (en_start && rst_at == 0 && nb < N) ? 1 : 0;
        e.busy  = en_start ? 1 : 0;
        if (e.done == 1) m_ramp = (m_ramp + 1) % 4096;
        if (rst_at > 0) m_ramp = 0;
        exp_tot_done += e.done;
        exp_tot_abort += e.abort;
        exp_q.push_back(e);

        for (int k = 0; k < 2; k++) begin
            spi_sck_i = 1'b0;
            wait_clk(hlf);
            spi_sck_i = 1'b1;
            wait_clk(hlf);
        end
        en_i = en_start;
        spi_cs_ni = 1'b0;
        wait_clk(2 * hlf);
        en_i = 1'($urandom_range(0, 1));
        for (int k = 1; k <= nb; k++) begin
            spi_sck_i = 1'b0;
            wait_clk(hlf);
            spi_sck_i = 1'b1;
            wait_clk(hlf);
            if (k == rst_at) begin
                rst = 1'b1;
                wait_clk(1);
                rst = 1'b0;
                wait_clk(6);
                req_chk++;
                wait_clk(2);
            end
        end
        wait_clk(hlf);
        spi_cs_ni = 1'b1;
        en_i = 1'b1;
        wait_clk(20);
    endtask

    initial begin
        wait_clk(3);
        req_chk++;
        wait_clk(2);
        rst = 1'b0;
        wait_clk(2);
        req_chk++;
        wait_clk(10);

        s0 = 12'hA5C;
        s1 = 12'h3F0;
        run_frame(16, 1'b1, 0, 4);
        run_frame(7, 1'b1, 0, 4);
        run_frame(16, 1'b1, 0, 4);
        s0 = 12'h123;
        s1 = 12'hEDC;
        run_frame(16, 1'b0, 0, 4);
        run_frame(16, 1'b1, 0, 5);
        run_frame(20, 1'b1, 0, 4);
        s0 = 12'hFFF;
        s1 = 12'h801;
        run_frame(16, 1'b1, 9, 4);
        run_frame(16, 1'b1, 0, 4);

        for (int i = 0; i < 12; i++) begin
            int sel;
            int nb;
            s0 = DW'($urandom);
            s1 = DW'($urandom);
            sel = int'($urandom_range(0, 3));
            nb = (sel == 0) ? int'($urandom_range(1, N - 1)) : (sel == 1) ? N + 4 : N;
            run_frame(nb, ($urandom_range(0, 3) != 0), 0, int'($urandom_range(4, 6)));
        end
        end_req = 1'b1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/spi_adc_responder.md
Name: spi_adc_responder

Overview:
Synthesizable SPI responder that emulates the dual-channel 12-bit serial ADC read by the multimeter's SPI ADC master. It sits on the slave side of the same 2-bit MISO interface (shared CS/SCK, one MISO line per channel) and serves loopback/self-test builds and simulation. Each frame shifts out LEAD_ZEROS zeros followed by a DATA_W-bit sample per channel, MSB first, changing data on SCK falling edges. All SPI inputs are oversampled in the system clock domain.

Parameters:
LEAD_ZEROS, 4, number of leading zero bits per frame before the sample MSB
DATA_W, 12, sample width in bits
SYNC_STAGES, 2, synchronizer flip-flop depth for spi_cs_ni and spi_sck_i (minimum 2)

Ports:
clk  in  1  system clock; all logic rising-edge on clk
rst  in  1  synchronous reset, active-high
en_i  in  1  responder enable; when low, frames are ignored and MISO is held 0
sample0_i  in  DATA_W  channel 0 value served on spi_miso_o[0]
sample1_i  in  DATA_W  channel 1 value served on spi_miso_o[1]
spi_cs_ni  in  1  SPI chip select from master, active low, asynchronous
spi_sck_i  in  1  SPI clock from master, idle high, asynchronous
spi_miso_o  out  2  serial data; bit 0 = channel 0, bit 1 = channel 1
busy_o  out  1  high while a frame is in progress
frame_done_o  out  1  one-cycle pulse when all LEAD_ZEROS+DATA_W bits have been shifted
frame_abort_o  out  1  one-cycle pulse when CS rises before the frame completes

Behaviour:
- Interface: one clock (clk); synchronous active-high reset (rst).
- Reset values: spi_miso_o=2'b00, busy_o=0, frame_done_o=0, frame_abort_o=0, bit counter=0, synchronizer stages=1 (CS and SCK idle high), FSM=IDLE.
- Synchronization: cs and sck pass through SYNC_STAGES flops, then one edge-detect register. Every SPI event takes effect on spi_miso_o exactly SYNC_STAGES+1 clk cycles after the pin edge. The master must hold each SCK half period for at least SYNC_STAGES+2 clk cycles.
- Frame length: N = LEAD_ZEROS + DATA_W (default 16). Bit counter width is clog2(N+1).
- FSM states: IDLE, SHIFT, DONE.
- IDLE: MISO=00. On a synchronized CS falling edge with en_i=1:
  - Load shift registers with {LEAD_ZEROS zeros, sample} per channel; sample0_i/sample1_i are captured in this cycle.
  - Drive the MSB (a zero) on MISO, set counter=0 and busy_o=1, go to SHIFT.
  - A CS falling edge with en_i=0 is ignored; the FSM stays in IDLE for the whole frame.
- SHIFT: on each synchronized SCK falling edge, shift left, present the next bit, counter++. When counter reaches N-1 and another SCK falling edge arrives, go to DONE, MISO=00, pulse frame_done_o.
- SHIFT, CS rising before completion: go to IDLE, MISO=00, busy_o=0, pulse frame_abort_o. No frame_done_o.
- DONE: MISO=00. Further SCK edges are ignored, with no wrap or reload. On CS rising: go to IDLE, busy_o=0, no pulse.
- Simultaneous CS rising and SCK falling in the same synchronized cycle: CS wins (abort, or close if in DONE).
- SCK rising edges are never used. SCK edges while CS is high are ignored.
- en_i dropping mid-frame does not affect the current frame; it gates only the start of a frame.
- rst asserted mid-frame: all state and outputs go to reset values on the next clk edge. A CS still low after reset release does not start a frame; only a new falling edge does.

Optional Feature:
ADC_RESP_RAMP_EN.
- Defined: sample0_i/sample1_i are ignored. Channel 0 serves an internal DATA_W-bit ramp that starts at 0 after reset and increments (wrapping at 2^DATA_W-1 to 0) on every frame_done_o. Channel 1 serves the bitwise inverse of the ramp. Aborted frames do not advance the ramp.
- Undefined: samples come from the ports and no ramp logic exists.

Test Plan:
- sample0_i=12'hA5C, sample1_i=12'h3F0; 16 SCK cycles (4 clk per half) with CS low -> master captures ch0=0x0A5C, ch1=0x03F0; frame_done_o pulses once; busy_o falls on CS rise.
- CS low, then 7 SCK falling edges, then CS rises -> frame_abort_o pulses once, no frame_done_o; the next full frame returns correct data.
- en_i=0 during CS fall, then a full frame -> MISO stays 00, busy_o stays 0, no pulses; with en_i=1 on the next frame -> correct data.
- 20 SCK falling edges in one CS-low window -> bits 17..20 read 0, exactly one frame_done_o.
- rst pulse at bit 9 while CS stays low -> outputs return to reset values, no frame starts until CS goes high then low again.
- ADC_RESP_RAMP_EN defined, 3 full frames plus 1 aborted frame -> ch0 reads 0x000, 0x001, 0x002 and ch1 reads 0xFFF, 0xFFE, 0xFFD; the abort leaves the next value at 0x003.
